// File: rtl/mips_run_controller.sv
// Run sequencer for the single-cycle MIPS core: host load,
// start/halt/timeout/abort control and data-memory readback.
module mips_run_controller #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              start,
  input  logic              abort,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_host_en,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              core_rst,
  input  logic              core_halt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              busy,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(MAX_CYCLES);

  logic [1:0]       state_q;
  logic             host_st;
  logic             rd_fire;
  logic [CNT_W-1:0] cnt_nxt;

  assign state        = state_q;
  assign host_st      = (state_q != S_RUN);
  assign busy         = ~host_st;
  assign host_ready   = host_st;
  assign dmem_host_en = host_st;
  assign core_rst     = host_st;

  assign imem_we    = host_st & host_valid & ~host_sel;
  assign imem_addr  = host_addr;
  assign imem_wdata = host_wdata;

  // A data write owns the shared address; a colliding read is dropped.
  assign dmem_we    = host_st & host_valid & host_sel;
  assign dmem_addr  = dmem_we ? host_addr : rd_addr;
  assign dmem_wdata = host_wdata;

  assign rd_fire = host_st & rd_req & ~dmem_we;

  assign cnt_nxt = (cycle_count == CNT_MAX) ?
    cycle_count : cycle_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_count <= '0;
      timeout     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire)
        rd_data <= dmem_rdata;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_RUN;
            cycle_count <= '0;
            timeout     <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_count <= cnt_nxt;
          if (abort) begin
            state_q <= S_IDLE;
            timeout <= 1'b0;
          end else if (core_halt) begin
            state_q <= S_DONE;
            timeout <= 1'b0;
          end else if (cnt_nxt == CNT_MAX) begin
            state_q <= S_DONE;
            timeout <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
